// File: rtl/xillybus_mem32_responder.sv
// Xillybus-style 32-bit seekable memory responder.
//
// DEPTH x 32-bit register-file memory shared by a host write stream and a host
// read stream through one auto-incrementing pointer. A seek (addr_update)
// sets the effective address for the access in the same cycle, or just loads
// the pointer when there is no access.
//
// Ports:
//   bus_clk_w                  clock, all logic on the rising edge
//   bus_rst_w                  synchronous active-high reset
//   user_mem_32_addr_w         seek address, low AW bits used
//   user_mem_32_addr_update_w  load seek address this cycle
//   user_w_mem_32_*            write stream: open, wren, data in; full out
//   user_r_mem_32_*            read stream: open, rden in; data, empty, eof out
//   GPIO_LED_w                 registered mirror of word 0 bits [3:0]
//
// Build option:
//   XILLYBUS_MEM32_EOF_EN  when defined, a read of the last word moves the read
//                          side to an end-of-file state (empty=1, eof=1) until
//                          the next seek. When undefined, reads wrap like
//                          writes and eof is tied low.

module xillybus_mem32_responder #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        bus_clk_w,
  input  logic        bus_rst_w,
  input  logic [31:0] user_mem_32_addr_w,
  input  logic        user_mem_32_addr_update_w,
  input  logic        user_w_mem_32_open_w,
  input  logic        user_w_mem_32_wren_w,
  input  logic [31:0] user_w_mem_32_data_w,
  output logic        user_w_mem_32_full_w,
  input  logic        user_r_mem_32_open_w,
  input  logic        user_r_mem_32_rden_w,
  output logic [31:0] user_r_mem_32_data_w,
  output logic        user_r_mem_32_empty_w,
  output logic        user_r_mem_32_eof_w,
  output logic [3:0]  GPIO_LED_w
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StClosed = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
`ifdef XILLYBUS_MEM32_EOF_EN
  localparam logic [1:0] StAtEof  = 2'd2;
`endif

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    state_q, state_d;
  logic          full_q, full_d;
  logic [3:0]    led_q, led_d;

  logic [AW-1:0] ea;
  logic          wr_en, rd_en, empty;

  // Upper address bits and the write-open flag do not affect behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{user_mem_32_addr_w[31:AW], user_w_mem_32_open_w};

  assign ea    = user_mem_32_addr_update_w ? user_mem_32_addr_w[AW-1:0] : ptr_q;
  assign empty = (state_q != StActive);
  assign wr_en = user_w_mem_32_wren_w & ~full_q;
  assign rd_en = user_r_mem_32_rden_w & ~empty;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[ea] = user_w_mem_32_data_w;
  end

  always_comb begin
    // A combined read+write still advances by one: both target the same ea.
    ptr_d = ptr_q;
    if (wr_en || rd_en) begin
      ptr_d = ea + AW'(1);
    end else if (user_mem_32_addr_update_w) begin
      ptr_d = ea;
    end
  end

  always_comb begin
    // mem_q holds pre-write contents, giving read-before-write on collisions.
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_q[ea];
  end

  always_comb begin
    state_d = state_q;
    if (!user_r_mem_32_open_w) begin
      state_d = StClosed;
    end else begin
      case (state_q)
        StClosed: state_d = StActive;
`ifdef XILLYBUS_MEM32_EOF_EN
        StActive: if (rd_en && (ea == AW'(DEPTH - 1))) state_d = StAtEof;
        StAtEof:  if (user_mem_32_addr_update_w) state_d = StActive;
`else
        StActive: state_d = StActive;
`endif
        default:  state_d = StClosed;
      endcase
    end
  end

  // Full only during reset and is released on the first cycle out of it.
  assign full_d = 1'b0;
  // Track next-state word 0 so the LEDs follow a write on the following cycle.
  assign led_d  = mem_d[0][3:0];

  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      state_q <= StClosed;
      full_q  <= 1'b1;
      led_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      full_q  <= full_d;
      led_q   <= led_d;
    end
  end

  assign user_w_mem_32_full_w  = full_q;
  assign user_r_mem_32_data_w  = rdata_q;
  assign user_r_mem_32_empty_w = empty;
`ifdef XILLYBUS_MEM32_EOF_EN
  assign user_r_mem_32_eof_w   = (state_q == StAtEof);
`else
  assign user_r_mem_32_eof_w   = 1'b0;
`endif
  assign GPIO_LED_w            = led_q;

endmodule

// File: tb/tb_xillybus_mem32_responder.sv
// Self-checking bench for xillybus_mem32_responder (DEPTH=16).
// Read data goes through a scoreboard queue; status flags are checked directly.

module tb_xillybus_mem32_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        upd;
  logic        w_open, wren;
  logic [31:0] wdata;
  logic        full;
  logic        r_open, rden;
  logic [31:0] rdata;
  logic        empty, eof;
  logic [3:0]  led;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic        rd_pend = 1'b0;

  always #5 clk = ~clk;

  xillybus_mem32_responder #(.DEPTH(16)) dut (
    .bus_clk_w                 (clk),
    .bus_rst_w                 (rst),
    .user_mem_32_addr_w        (addr),
    .user_mem_32_addr_update_w (upd),
    .user_w_mem_32_open_w      (w_open),
    .user_w_mem_32_wren_w      (wren),
    .user_w_mem_32_data_w      (wdata),
    .user_w_mem_32_full_w      (full),
    .user_r_mem_32_open_w      (r_open),
    .user_r_mem_32_rden_w      (rden),
    .user_r_mem_32_data_w      (rdata),
    .user_r_mem_32_empty_w     (empty),
    .user_r_mem_32_eof_w       (eof),
    .GPIO_LED_w                (led)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: a strobe driven in one cycle yields data after that edge.
  always @(posedge clk) rd_pend <= rden;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rdata_unexpected: got 0x%08h expected no read", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd = 1'b0; wren = 1'b0; rden = 1'b0;
  endtask

  task automatic wr(input logic seek, input logic [31:0] a, input logic [31:0] d);
    upd = seek; addr = a; wren = 1'b1; wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic seek, input logic [31:0] a, input logic [31:0] exp);
    upd = seek; addr = a; rden = 1'b1;
    exp_q.push_back(exp);
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; addr = '0; upd = 1'b0; w_open = 1'b0; wren = 1'b0; wdata = '0;
    r_open = 1'b0; rden = 1'b0;
    tick(); tick();
    chk("rst_full",  {31'd0, full},  32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_eof",   {31'd0, eof},   32'd0);
    chk("rst_led",   {28'd0, led},   32'd0);
    chk("rst_rdata", rdata,          32'd0);

    rst = 1'b0;
    tick();
    chk("full_release", {31'd0, full}, 32'd0);

    // Seek-and-write, then sequential write.
    w_open = 1'b1;
    wr(1'b1, 32'd3, 32'hDEADBEEF);
    wr(1'b0, 32'd0, 32'h12345678);

    r_open = 1'b1;
    tick();
    chk("open_empty", {31'd0, empty}, 32'd0);
    chk("open_eof",   {31'd0, eof},   32'd0);

    // Two back-to-back reads from seek 3.
    upd = 1'b1; addr = 32'd3; rden = 1'b1; exp_q.push_back(32'hDEADBEEF);
    tick();
    upd = 1'b0; exp_q.push_back(32'h12345678);
    tick();
    idle();

    // Pointer now 5: unseeked write lands there.
    wr(1'b0, 32'd0, 32'h55555555);
    rd(1'b1, 32'd5, 32'h55555555);

    // Simultaneous read/write at ptr=7.
    wr(1'b1, 32'd7, 32'h00000001);
    wr(1'b0, 32'd0, 32'h00000088);
    upd = 1'b1; addr = 32'd7;
    tick();
    idle();
    wren = 1'b1; wdata = 32'hA5A5A5A5; rden = 1'b1; exp_q.push_back(32'h00000001);
    tick();
    idle();
    rd(1'b0, 32'd0, 32'h00000088);
    rd(1'b1, 32'd7, 32'hA5A5A5A5);

    // Read while closed is ignored: data and pointer hold.
    r_open = 1'b0;
    tick();
    chk("closed_empty", {31'd0, empty}, 32'd1);
    rd(1'b0, 32'd0, 32'hA5A5A5A5);
    r_open = 1'b1;
    tick();
    wr(1'b1, 32'd8, 32'h00000099);
    rd(1'b1, 32'd8, 32'h00000099);
    rd(1'b1, 32'd7, 32'hA5A5A5A5);
    r_open = 1'b0;
    tick();
    rd(1'b0, 32'd0, 32'hA5A5A5A5);
    r_open = 1'b1;
    tick();
    rd(1'b0, 32'd0, 32'h00000099);

    // LED mirror of word 0.
    wr(1'b1, 32'd0, 32'h0000000C);
    chk("led_write", {28'd0, led}, 32'hC);

`ifdef XILLYBUS_MEM32_EOF_EN
    wr(1'b1, 32'd14, 32'h0000000E);
    wr(1'b0, 32'd0,  32'h0000000F);
    rd(1'b1, 32'd14, 32'h0000000E);
    rd(1'b0, 32'd0,  32'h0000000F);
    chk("eof_empty", {31'd0, empty}, 32'd1);
    chk("eof_flag",  {31'd0, eof},   32'd1);
    rd(1'b0, 32'd0, 32'h0000000F);
    chk("eof_hold", {31'd0, eof}, 32'd1);
    upd = 1'b1; addr = 32'd0;
    tick();
    idle();
    chk("eof_clr_empty", {31'd0, empty}, 32'd0);
    chk("eof_clr_eof",   {31'd0, eof},   32'd0);
    rd(1'b0, 32'd0, 32'h0000000C);
`else
    wr(1'b1, 32'd15, 32'h00000F15);
    rd(1'b1, 32'd15, 32'h00000F15);
    rd(1'b0, 32'd0,  32'h0000000C);
    chk("wrap_eof",   {31'd0, eof},   32'd0);
    chk("wrap_empty", {31'd0, empty}, 32'd0);
`endif

    // Reset mid-transfer discards the write and clears everything.
    rst = 1'b1; upd = 1'b1; addr = 32'd0; wren = 1'b1; wdata = 32'h00000007;
    tick();
    idle();
    chk("rst2_full",  {31'd0, full},  32'd1);
    chk("rst2_led",   {28'd0, led},   32'd0);
    chk("rst2_rdata", rdata,          32'd0);
    chk("rst2_empty", {31'd0, empty}, 32'd1);
    rst = 1'b0;
    tick();
    chk("rst2_full_release", {31'd0, full}, 32'd0);
    rd(1'b1, 32'd0, 32'h00000000);
    rd(1'b1, 32'd7, 32'h00000000);

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
